sort_check_scheduler: RTL and testbench

Shares one array sort-check engine (the Lab3 datapath plus its control FSM) among `N` requesters. Arbitrates round-robin, latches the winner's array base address and length onto the engine, and sequences the engine's `go`/`done` handshake. Returns a one-cycle sorted/unsorted/timeout response to the granted requester. Sits between the requester-side buses and the single engine instance.

---
 rtl/sort_check_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/sort_check_scheduler.sv | 149 ++++++++++++++
 tb/tb_sort_check_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_check_pkg.sv
// sort_check_pkg
// Shared definitions for the sort-check scheduler slice.
//   state_t  : scheduler FSM encoding (IDLE=0, ISSUE=1, BUSY=2, RESPOND=3)
//   ADDR_W   : default array base address width
//   LEN_W    : default array length width
package sort_check_pkg;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search starts at requester
// index ptr and wraps, so the requester at ptr has the highest priority.
//   req   : per-requester request bits
//   ptr   : index with highest priority this decision
//   grant : one-hot winner (all zero when req is zero)
//   idx   : binary index of the winner (zero when req is zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sort_check_scheduler.sv
// sort_check_scheduler
// Shares one sort-check engine among N requesters. A round-robin winner has
// its base address and length latched onto the engine, the engine is started
// with a one-cycle go pulse, and the finished result is returned to the
// winner as a one-cycle response.
//
// Handshakes:
//   requester side: req[i] is a level held until resp_valid[i]; resp_valid is
//   a one-hot single-cycle pulse qualifying resp_sorted / resp_timeout. If
//   req[g] drops while its job is in flight the pulse is suppressed.
//   engine side: eng_go is a single-cycle start strobe with eng_addr/eng_len
//   stable from the go cycle until the response cycle; eng_done is a level
//   held until the next go and qualifies eng_sorted.
//
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   req/req_addr/req_len : packed requester buses, slice i = [i*W +: W]
//   resp_valid/resp_sorted/resp_timeout : registered response
//   busy              : job in flight (ISSUE, BUSY or RESPOND)
//   eng_go/eng_addr/eng_len : registered engine command
//   eng_done/eng_sorted : engine status
//   dbgState          : current FSM state (sort_check_pkg::state_t encoding)
module sort_check_scheduler #(
  parameter int N       = 4,
  parameter int ADDR_W  = sort_check_pkg::ADDR_W,
  parameter int LEN_W   = sort_check_pkg::LEN_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic [N*LEN_W-1:0]  req_len,
  output logic [N-1:0]        resp_valid,
  output logic                resp_sorted,
  output logic                resp_timeout,
  output logic                busy,
  output logic                eng_go,
  output logic [ADDR_W-1:0]   eng_addr,
  output logic [LEN_W-1:0]    eng_len,
  input  logic                eng_done,
  input  logic                eng_sorted,
  output logic [1:0]          dbgState
);

  import sort_check_pkg::*;

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gIdx;
  logic [N-1:0]  gOneHot;
  logic [CW-1:0] tCnt;
  logic          dropped;

  logic [N-1:0]  winGrant;
  logic [IW-1:0] winIdx;
  logic          stillWanted;
  logic [N-1:0]  respMask;
  logic [IW-1:0] nextPtr;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (winGrant),
    .idx   (winIdx)
  );

  // A requester that let go at any point during its job gets no pulse, even
  // if it has raised req again by the time the engine finishes.
  assign stillWanted = |(req & gOneHot) && !dropped;
  assign respMask    = stillWanted ? gOneHot : '0;
  assign nextPtr     = (gIdx == IW'(N - 1)) ? '0 : gIdx + 1'b1;
  assign dbgState    = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gIdx         <= '0;
      gOneHot      <= '0;
      tCnt         <= '0;
      dropped      <= 1'b0;
      eng_go       <= 1'b0;
      eng_addr     <= '0;
      eng_len      <= '0;
      resp_valid   <= '0;
      resp_sorted  <= 1'b0;
      resp_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // eng_addr/eng_len only move on a grant.
          if (|req) begin
            eng_addr <= req_addr[int'(winIdx)*ADDR_W +: ADDR_W];
            eng_len  <= req_len[int'(winIdx)*LEN_W +: LEN_W];
            gIdx     <= winIdx;
            gOneHot  <= winGrant;
            tCnt     <= '0;
            dropped  <= 1'b0;
            eng_go   <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          // done is not sampled here: it may still be high from the previous
          // job until the engine has seen this go.
          eng_go <= 1'b0;
          if (!(|(req & gOneHot))) dropped <= 1'b1;
          state  <= BUSY;
        end

        BUSY: begin
          if (!(|(req & gOneHot))) dropped <= 1'b1;
          if (tCnt != CNT_MAX) tCnt <= tCnt + 1'b1;
          if (eng_done) begin
            resp_sorted  <= eng_sorted;
            resp_timeout <= 1'b0;
            resp_valid   <= respMask;
            state        <= RESPOND;
          end else if (tCnt == CNT_MAX) begin
            resp_sorted  <= 1'b0;
            resp_timeout <= 1'b1;
            resp_valid   <= respMask;
            state        <= RESPOND;
          end
        end

        RESPOND: begin
          resp_valid   <= '0;
          resp_sorted  <= 1'b0;
          resp_timeout <= 1'b0;
          ptr          <= nextPtr;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_check_scheduler.sv
module tb_sort_check_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int TO = 20;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic            eng_done = 1'b0;
  logic            eng_sorted = 1'b0;
  logic [N-1:0]    resp_valid;
  logic            resp_sorted;
  logic            resp_timeout;
  logic            busy;
  logic            eng_go;
  logic [AW-1:0]   eng_addr;
  logic [LW-1:0]   eng_len;
  logic [1:0]      dbgState;

  sort_check_scheduler #(
    .N(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .resp_valid   (resp_valid),
    .resp_sorted  (resp_sorted),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .eng_go       (eng_go),
    .eng_addr     (eng_addr),
    .eng_len      (eng_len),
    .eng_done     (eng_done),
    .eng_sorted   (eng_sorted),
    .dbgState     (dbgState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int mptr = 0;                 // reference round-robin pointer
  int respCount[N];
  logic [N+1:0] exp_q[$];       // {valid one-hot, sorted, timeout}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference arbitration: first requesting index scanning upward from p.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_job(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  // One complete job, called with the DUT idle and req already set.
  // The engine keeps done high from the previous job until the first BUSY
  // cycle, so a scheduler that sampled done too early would be caught.
  task automatic serve(input int lat, input bit srt, input bit hang, input bit dropIt);
    int g;
    bit seen;
    bit early;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    logic [N-1:0]  oh;
    logic [N+1:0]  e;
    g  = pick(req, mptr);
    ea = req_addr[g*AW +: AW];
    el = req_len[g*LW +: LW];
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (eng_go === 1'b1) seen = 1'b1;
    end
    chk("go_seen", seen, 1);
    if (!seen) return;
    chk("eng_addr", eng_addr, ea);
    chk("eng_len", eng_len, el);
    chk("busy_issue", busy, 1);
    step();
    chk("go_one_cycle", eng_go, 0);
    eng_done = 1'b0;
    if (dropIt) req[g] = 1'b0;
    oh = '0;
    if (!dropIt) oh[g] = 1'b1;
    e = {oh, srt && !hang, hang};
    exp_q.push_back(e);
    if (hang) begin
      early = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        step();
        if (resp_valid !== '0) early = 1'b1;
      end
      chk("no_early_resp", early, 0);
      step();
    end else begin
      repeat (lat) step();
      eng_done   = 1'b1;
      eng_sorted = srt;
      step();
    end
    e = exp_q.pop_front();
    chk("resp_valid", resp_valid, e[N+1:2]);
    if (e[N+1:2] != '0) begin
      chk("resp_sorted", resp_sorted, e[1]);
      chk("resp_timeout", resp_timeout, e[0]);
    end
    chk("addr_stable", eng_addr, ea);
    chk("len_stable", eng_len, el);
    for (int i = 0; i < N; i++) if (resp_valid[i] === 1'b1) respCount[i]++;
    mptr = (g + 1) % N;
    step();
    chk("resp_pulse_end", resp_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_sorted"}, resp_sorted, 0);
    chk({tag, "_resp_timeout"}, resp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eng_go"}, eng_go, 0);
    chk({tag, "_eng_addr"}, eng_addr, 0);
    chk({tag, "_eng_len"}, eng_len, 0);
    chk({tag, "_state"}, dbgState, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit seen;
    int g;
    for (int i = 0; i < N; i++) respCount[i] = 0;

    // Reset state
    #12;
    chk_all_zero("reset");
    step();
    reset = 1'b1;
    step();

    // Single request
    set_job(0, 32'h100, 32'd5);
    req = 4'b0001;
    serve(12, 1'b1, 1'b0, 1'b0);
    req = '0;

    // Round-robin fairness with every requester waiting
    for (int i = 0; i < N; i++) set_job(i, $urandom, $urandom_range(1, 1000));
    for (int i = 0; i < N; i++) respCount[i] = 0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (k == N - 1)
        for (int i = 0; i < N; i++) chk("rr_one_each", respCount[i], 1);
    end
    req = '0;

    // Timeout, then a normal job
    set_job(1, $urandom, $urandom_range(1, 100));
    req = 4'b0010;
    serve(0, 1'b1, 1'b1, 1'b0);
    req = '0;
    set_job(0, $urandom, $urandom_range(1, 100));
    req = 4'b0001;
    serve($urandom_range(1, 10), 1'b1, 1'b0, 1'b0);
    req = '0;

    // Requester drop: req[2] alone, dropped in BUSY
    set_job(2, $urandom, $urandom_range(1, 100));
    req = 4'b0100;
    serve($urandom_range(2, 10), 1'b1, 1'b0, 1'b1);

    // req[2] re-raised with req[3] pending: pointer moved past 2, so 3 wins.
    // Reset lands while that job is in BUSY.
    set_job(3, $urandom, $urandom_range(1, 100));
    req = 4'b1100;
    g = pick(req, mptr);
    chk("model_winner_after_drop", g, 3);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (eng_go === 1'b1) seen = 1'b1;
    end
    chk("rst_go_seen", seen, 1);
    chk("rst_job_addr", eng_addr, req_addr[3*AW +: AW]);
    step();
    eng_done = 1'b0;
    step();
    step();
    #3 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    mptr = 0;
    step();
    reset = 1'b1;

    // After release the pointer is 0 again, so req[2] beats req[3].
    serve($urandom_range(1, 10), 1'b0, 1'b0, 1'b0);
    req = '0;

    // Zero length with stale done (sorted=0) still high at grant
    set_job(0, $urandom, 32'd0);
    req = 4'b0001;
    serve(4, 1'b1, 1'b0, 1'b0);
    req = '0;

    // Random traffic
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) set_job(i, $urandom, $urandom);
      req = 4'($urandom_range(1, 15));
      serve($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b0,
            $urandom_range(0, 5) == 0);
      req = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
